uart_rom_loader: RTL
====================

# uart_rom_loader

Boot loader that sits directly upstream of the instruction ROM and CPU on `mother_board`. It receives a program image over the board's UART RX line (8N1, `WAIT` clocks per bit), assembles little-endian 32-bit words, writes them into the instruction ROM from address 0, and holds the CPU in reset until the image is complete. It replaces the hand-poked ROM contents used in simulation with a real load path.

## Interface
- `WAIT`, 8, clocks per UART bit; must be even and ≥ 4
- `ADDR_W`, 10, ROM word-address width; capacity `2**ADDR_W` words
- `clk`  input  1  system clock
- `reset`  input  1  synchronous, active-high reset
- `uart_rx`  input  1  asynchronous UART line, idle high
- `we`  output  1  ROM write strobe, one-cycle pulse per word
- `waddr`  output  `ADDR_W`  ROM word address for `we`
- `wdata`  output  32  ROM word for `we`
- `cpu_reset`  output  1  held high until load completes; drives CPU reset (ORed with `reset` at board level)
- `busy`  output  1  a load is in progress (at least one header byte received, not yet DONE/ERROR)
- `done`  output  1  sticky; image fully written
- `error`  output  1  sticky; load aborted

## Operation
- All state changes on rising `clk`. One clock domain, one synchronous, active-high reset.
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0. The RX synchronizer flops reset to 1.
- Image format: 2-byte word count N (little-endian), then 4·N bytes. Each word is byte0 in [7:0] through byte3 in [31:24].

Byte receiver (IDLE, START, DATA, STOP):
- `uart_rx` passes through a 2-flop synchronizer. IDLE looks for a high→low transition on the synchronized line, at cycle t0.
- START: resample at t0+WAIT/2. If the line is low, go to DATA. If high, this is a glitch: return to IDLE and emit no byte.
- DATA: sample bit k (LSB first, k=0..7) at t0+WAIT/2+(k+1)·WAIT.
- STOP: sample at t0+WAIT/2+9·WAIT.
  - High: the byte is valid at that cycle.
  - Low: framing error.
  - In both cases return to IDLE; the next start can be detected from the following cycle.

Loader FSM (HDR0, HDR1, DATA, DONE, ERROR):
- HDR0: the first valid byte is the count low byte; go to HDR1 and set `busy`.
- HDR1: the second byte is the count high byte.
  - N=0: go to DONE.
  - N > 2**ADDR_W: go to ERROR.
  - Otherwise go to DATA.
- DATA: shift bytes into a 2-bit byte index and 32-bit assembler. On the 4th byte, drive `we`=1 with `wdata` = the assembled word and `waddr` = the current address. Then increment the address and the word counter. After word N, go to DONE.
- DONE: `done`=1, `cpu_reset`=0, `busy`=0. Further RX bytes are ignored.
- ERROR:
  - Entered on a framing error in any state before DONE, or on an oversize count.
  - Sets `error`=1 and `busy`=0; `cpu_reset` stays 1.
  - Only `reset` leaves ERROR.
- `waddr` holds its last written address between strokes. `wdata` holds its last value.
- No write wraps: the address never exceeds N−1 ≤ 2**ADDR_W−1.

## Timing
- Start detection lags the line by 2 cycles (synchronizer).
- Nominal byte period: 10·WAIT clocks. Back-to-back frames must be accepted with zero idle bits.
- `we` asserts on the cycle after the 4th byte's stop-bit sample, for exactly 1 cycle.
- `done` rises and `cpu_reset` falls on the cycle after the last `we`, together.
- For N=0, `done` rises the cycle after the 2nd header byte's stop sample.
- ERROR is entered the cycle after the offending stop sample or count byte.
- `reset` asserted mid-load, mid-byte, or in DONE/ERROR:
  - Next cycle all outputs take their reset values.
  - The partial word and count are discarded.
  - The receiver returns to IDLE.
  - `cpu_reset` reasserts.

## Test plan
- WAIT=8, send 02 00 00 01 10 00 0A 00 00 00 → `we` at `waddr`=0 with `wdata`=0x00100100, then `waddr`=1 with 0x0000000A. `done`=1 and `cpu_reset`=0 one cycle after the 2nd `we`. On the CPU side, x[1]=1 afterwards.
- Send 00 00 → no `we`; `done`=1, `cpu_reset`=0, `error`=0.
- ADDR_W=4, send 11 00 (N=17) → `error`=1, `cpu_reset`=1, no `we`. Further bytes are ignored.
- Hold `uart_rx` low for 3 clocks (< WAIT/2) then high → no byte, FSM stays HDR0, `busy`=0.
- Header 01 00, then a byte with stop bit driven low → `error`=1, no `we`. After `reset`, a valid image of 01 00 0A 00 00 00 loads with `wdata`=0x0000000A and `done`=1.
- Assert `reset` after 2 of 4 data bytes of a 1-word image, then resend the full image → exactly one `we` at address 0 with the full word; no stale bytes mixed in.

Source files
------------

// File: rtl/uart_rom_loader.sv
// uart_rom_loader
//   Boot loader for the instruction ROM. Receives a program image over an
//   8N1 UART line (WAIT clocks per bit). The image is a 2-byte little-endian
//   word count N followed by 4*N bytes. Each group of four bytes is
//   assembled little-endian into a 32-bit word and written to the ROM,
//   starting at address 0. The CPU is held in reset until the whole image
//   has been written.
//
// Parameters
//   WAIT    clocks per UART bit (even, >= 4)
//   ADDR_W  ROM word-address width; capacity is 2**ADDR_W words
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   uart_rx    asynchronous UART line, idle high
//   we         ROM write strobe, one-cycle pulse per word
//   waddr      ROM word address qualified by we
//   wdata      ROM word qualified by we
//   cpu_reset  high until the image is complete
//   busy       a load is in progress
//   done       sticky, image fully written
//   error      sticky, load aborted (framing error or oversize count)
module uart_rom_loader #(
  parameter int WAIT   = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW = $clog2(WAIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(WAIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(WAIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [32:0]   CAPACITY = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_HDR0, LD_HDR1, LD_DATA, LD_DONE, LD_ERROR} ld_state_t;

  rx_state_t         rx_state;
  logic              rx_meta;
  logic              rx_sync;
  logic              rx_prev;
  logic [CW-1:0]     tick_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        rx_shift;

  logic              stop_tick;
  logic              byte_ok;
  logic              frame_err;

  ld_state_t         ld_state;
  logic [7:0]        count_lo;
  logic [15:0]       new_count;
  logic [15:0]       n_words;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_idx;
  logic [23:0]       word_asm;
  logic [ADDR_W-1:0] addr;

  // Byte receiver. tick_cnt is loaded with 1 on each state entry so that a
  // sample happens exactly when it reaches the target count, which puts the
  // start check at t0+WAIT/2 and every later sample one full bit apart.
  // rx_prev keeps tracking the line in every state, so a start bit that
  // follows a stop bit with no idle time is still seen as a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            tick_cnt <= CNT_ONE;
          end
        end
        RX_START: begin
          if (tick_cnt == HALF_BIT) begin
            if (!rx_sync) begin
              rx_state <= RX_DATA;
              tick_cnt <= CNT_ONE;
              bit_idx  <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (tick_cnt == FULL_BIT) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            tick_cnt <= CNT_ONE;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 3'd1;
          end else begin
            tick_cnt <= tick_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (tick_cnt == FULL_BIT) rx_state <= RX_IDLE;
          else                      tick_cnt <= tick_cnt + CNT_ONE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // The stop-bit sample cycle is when the loader consumes the byte, so the
  // loader's registered outputs change on the following cycle.
  assign stop_tick = (rx_state == RX_STOP) && (tick_cnt == FULL_BIT);
  assign byte_ok   = stop_tick && rx_sync;
  assign frame_err = stop_tick && !rx_sync;
  assign new_count = {rx_shift, count_lo};

  // Loader FSM. Bytes 0..2 of a word accumulate in word_asm (newest byte on
  // top); the 4th byte completes the word straight into wdata. Completion is
  // detected on the cycle we is high so that done follows the last write by
  // exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state  <= LD_HDR0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      count_lo  <= '0;
      n_words   <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      word_asm  <= '0;
      addr      <= '0;
    end else begin
      we <= 1'b0;
      case (ld_state)
        LD_HDR0: begin
          if (frame_err) begin
            ld_state <= LD_ERROR;
            error    <= 1'b1;
            busy     <= 1'b0;
          end else if (byte_ok) begin
            count_lo <= rx_shift;
            busy     <= 1'b1;
            ld_state <= LD_HDR1;
          end
        end
        LD_HDR1: begin
          if (frame_err) begin
            ld_state <= LD_ERROR;
            error    <= 1'b1;
            busy     <= 1'b0;
          end else if (byte_ok) begin
            n_words  <= new_count;
            word_cnt <= '0;
            byte_idx <= '0;
            addr     <= '0;
            if (new_count == 16'd0) begin
              ld_state  <= LD_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              busy      <= 1'b0;
            end else if ({17'd0, new_count} > CAPACITY) begin
              ld_state <= LD_ERROR;
              error    <= 1'b1;
              busy     <= 1'b0;
            end else begin
              ld_state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (frame_err) begin
            ld_state <= LD_ERROR;
            error    <= 1'b1;
            busy     <= 1'b0;
          end else if (we && (word_cnt == n_words)) begin
            ld_state  <= LD_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
          end else if (byte_ok) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              we       <= 1'b1;
              wdata    <= {rx_shift, word_asm};
              waddr    <= addr;
              addr     <= addr + 1'b1;
              word_cnt <= word_cnt + 16'd1;
            end else begin
              word_asm <= {rx_shift, word_asm[23:8]};
            end
          end
        end
        LD_DONE:  ld_state <= LD_DONE;
        LD_ERROR: ld_state <= LD_ERROR;
        default:  ld_state <= LD_HDR0;
      endcase
    end
  end

endmodule
